ext_mem_ws: RTL and testbench

// - Parametrised word-organised data memory behind the LSU, with configurable wait states and a real ready handshake.
// - One request is in flight at a time; the requester must honour ready_o.
// - Adds a response strobe (valid_o), an address error flag (err_o) and byte-lane writes for any DATA_W.
// - Sits between the LSU and the core's data-memory port; with LATENCY=0 it acts as a one-cycle synchronous RAM.

---
 rtl/ext_mem_pkg.sv | 9 +
 rtl/byte_lane_merge.sv | 18 +
 rtl/ext_mem_ws.sv | 149 ++++++++++++++
 tb/tb_ext_mem_ws.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and response fill patterns for the wait-stated external data memory.
package ext_mem_pkg;

    typedef enum logic {IDLE, WAIT} ext_mem_state_t;

    localparam logic [31:0] FILL_WRITE   = 32'hfa11_1eaf;
    localparam logic [31:0] FILL_INVALID = 32'hdead_beef;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with be set take new_word, the rest keep old_word.
module byte_lane_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (be[k]) merged[k*8 +: 8] = new_word[k*8 +: 8];
        end
    end

endmodule

// File: rtl/ext_mem_ws.sv
// Word-organised data memory with programmable wait states, ready/valid handshake,
// byte-lane writes and an out-of-range error strobe.
//
// state | meaning
// IDLE  | ready_o=1; accepts a request (LATENCY=0: accesses on the same edge)
// WAIT  | request captured; down-counter runs, access fires when it reads zero
module ext_mem_ws
    import ext_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    DATA_W      = 32,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_req_i,
    input  logic                write_enable_i,
    input  logic [DATA_W/8-1:0] byte_enable_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   write_data_i,
    output logic [DATA_W-1:0]   read_data_o,
    output logic                ready_o,
    output logic                valid_o,
    output logic                err_o
);

    localparam int          BYTES    = DATA_W / 8;
    localparam int          LG       = $clog2(BYTES);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] LIMIT    = 64'(DEPTH_WORDS) * 64'(BYTES);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam int          REP      = (DATA_W + 31) / 32;
    localparam logic [REP*32-1:0] FW_REP = {REP{FILL_WRITE}};
    localparam logic [REP*32-1:0] FI_REP = {REP{FILL_INVALID}};

    ext_mem_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              capture;

    logic [AW-1:0]     idx_q;
    logic              we_q, oor_q;
    logic [BYTES-1:0]  be_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_oor;
    logic [AW-1:0]     req_idx;

    logic              acc_fire, acc_we, acc_oor;
    logic [AW-1:0]     acc_idx;
    logic [BYTES-1:0]  acc_be;
    logic [DATA_W-1:0] acc_wdata;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] old_word, merged_word;
    logic [DATA_W-1:0] fill_write_w, fill_invalid_w;

    assign fill_write_w   = FW_REP[DATA_W-1:0];
    assign fill_invalid_w = FI_REP[DATA_W-1:0];

    // Range check uses the full byte address so wrap-around aliases are flagged.
    assign req_oor = {32'b0, addr_i} >= LIMIT;
    assign req_idx = addr_i[LG +: AW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        acc_fire  = 1'b0;
        acc_idx   = idx_q;
        acc_we    = we_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        acc_oor   = oor_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if (LATENCY == 0) begin
                        acc_fire  = 1'b1;
                        acc_idx   = req_idx;
                        acc_we    = write_enable_i;
                        acc_be    = byte_enable_i;
                        acc_wdata = write_data_i;
                        acc_oor   = req_oor;
                    end else begin
                        capture = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_fire = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            read_data_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_o <= (state_d == IDLE);
            valid_o <= acc_fire;
            err_o   <= acc_fire && acc_oor;
            if (acc_fire) begin
                if (acc_oor)     read_data_o <= fill_invalid_w;
                else if (acc_we) read_data_o <= fill_write_w;
                else             read_data_o <= mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            idx_q   <= req_idx;
            we_q    <= write_enable_i;
            be_q    <= byte_enable_i;
            wdata_q <= write_data_i;
            oor_q   <= req_oor;
        end
    end

    assign old_word = mem[acc_idx];

    byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (old_word),
        .new_word (acc_wdata),
        .be       (acc_be),
        .merged   (merged_word)
    );

    always_ff @(posedge clk_i) begin
        if (acc_fire && acc_we && !acc_oor) mem[acc_idx] <= merged_word;
    end

endmodule

// File: tb/tb_ext_mem_ws.sv
// Bench for ext_mem_ws: a LATENCY=2 and a LATENCY=0 instance checked against a word-array model.
module tb_ext_mem_ws;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_i = 1'b1;

    logic        req_a, we_a, rdy_a, vld_a, err_a;
    logic [3:0]  be_a;
    logic [31:0] addr_a, wd_a, rd_a;
    logic        req_z, we_z, rdy_z, vld_z, err_z;
    logic [3:0]  be_z;
    logic [31:0] addr_z, wd_z, rd_z;

    ext_mem_ws #(.DEPTH_WORDS(DEPTH), .DATA_W(32), .LATENCY(LAT), .INIT_FILE("")) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(req_a), .write_enable_i(we_a),
        .byte_enable_i(be_a), .addr_i(addr_a), .write_data_i(wd_a),
        .read_data_o(rd_a), .ready_o(rdy_a), .valid_o(vld_a), .err_o(err_a));

    ext_mem_ws #(.DEPTH_WORDS(DEPTH), .DATA_W(32), .LATENCY(0), .INIT_FILE("")) dut_z (
        .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(req_z), .write_enable_i(we_z),
        .byte_enable_i(be_z), .addr_i(addr_z), .write_data_i(wd_z),
        .read_data_o(rd_z), .ready_o(rdy_z), .valid_o(vld_z), .err_o(err_z));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_z [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory of DEPTH words, out-of-range returns the invalid pattern.
    function automatic void ref_acc(input bit z, input bit we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] ed, output logic ee);
        int idx;
        logic [31:0] w;
        if (addr >= 32'(DEPTH * 4)) begin
            ed = 32'hdead_beef;
            ee = 1'b1;
            return;
        end
        ee  = 1'b0;
        idx = int'(addr >> 2);
        w   = z ? mdl_z[idx] : mdl_a[idx];
        if (we) begin
            for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
            if (z) mdl_z[idx] = w; else mdl_a[idx] = w;
            ed = 32'hfa11_1eaf;
        end else begin
            ed = w;
        end
    endfunction

    // Called at a negedge with instance A idle; returns at the negedge where valid_o is seen.
    task automatic txn_a(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int rdy_low);
        chk("ready_before_req", 32'(rdy_a), 32'd1);
        req_a = 1'b1; we_a = we; be_a = be; addr_a = addr; wd_a = wd;
        @(negedge clk_i);
        req_a = 1'b0;
        lat = 1; rdy_low = 0;
        while (!vld_a && lat < 40) begin
            if (!rdy_a) rdy_low++;
            @(negedge clk_i);
            lat++;
        end
        rd = rd_a; er = err_a;
        if (!vld_a) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout: no valid_o after %0d cycles, addr %h", lat, addr);
        end
        chk("ready_at_valid", 32'(rdy_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed, rd, na;
        logic        ee, er;
        int          lat, rl, t0, vcount;
        logic [31:0] pool [8];
        bit          act;
        vec_t        v;

        req_a = 0; we_a = 0; be_a = 0; addr_a = 0; wd_a = 0;
        req_z = 0; we_z = 0; be_z = 0; addr_z = 0; wd_z = 0;

        vecs.push_back('{1'b1, 4'hF, 32'h0000_0100, 32'hA5A5_1234, 32'hfa11_1eaf, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'hA5A5_1234, 1'b0});
        vecs.push_back('{1'b1, 4'h5, 32'h0000_0100, 32'hFFFF_FFFF, 32'hfa11_1eaf, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'hA5FF_12FF, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_3FFC, 32'h0BAD_F00D, 32'hfa11_1eaf, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_4000, 32'h0,         32'hdead_beef, 1'b1});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_4000, 32'h1234_5678, 32'hdead_beef, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_3FFC, 32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hfa11_1eaf, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'h0000_0103, 32'h0,         32'hA5FF_12FF, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'hdead_beef, 1'b1});
        vecs.push_back('{1'b1, 4'hF, 32'h0000_0200, 32'h2222_2222, 32'hfa11_1eaf, 1'b0});

        #2 rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_valid", 32'(vld_a), 32'd0);
        chk("rst_err",   32'(err_a), 32'd0);
        chk("rst_rdata", rd_a,       32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            txn_a(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, rd, er, lat, rl);
            chk($sformatf("a_vec%0d_data", i), rd, vecs[i].exp_d);
            chk($sformatf("a_vec%0d_err", i), 32'(er), 32'(vecs[i].exp_e));
            chk($sformatf("a_vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
            chk($sformatf("a_vec%0d_ready_low", i), 32'(rl), 32'(LAT));
            ref_acc(1'b0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, ed, ee);
        end

        foreach (vecs[i]) begin
            req_z = 1'b1; we_z = vecs[i].we; be_z = vecs[i].be;
            addr_z = vecs[i].addr; wd_z = vecs[i].wd;
            @(negedge clk_i);
            chk($sformatf("z_vec%0d_valid", i), 32'(vld_z), 32'd1);
            chk($sformatf("z_vec%0d_ready", i), 32'(rdy_z), 32'd1);
            chk($sformatf("z_vec%0d_data", i), rd_z, vecs[i].exp_d);
            chk($sformatf("z_vec%0d_err", i), 32'(err_z), 32'(vecs[i].exp_e));
            ref_acc(1'b1, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, ed, ee);
        end
        req_z = 1'b0;
        @(negedge clk_i);
        chk("z_idle_valid", 32'(vld_z), 32'd0);

        // A write request held through WAIT must be ignored.
        req_a = 1'b1; we_a = 1'b0; be_a = 4'h0; addr_a = 32'h100; wd_a = 32'h0;
        @(negedge clk_i);
        we_a = 1'b1; be_a = 4'hF; wd_a = 32'h0;
        vcount = 0; rd = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            if (vld_a) begin
                vcount++;
                if (vcount == 1) rd = rd_a;
                req_a = 1'b0;
            end
            @(negedge clk_i);
        end
        chk("busy_valid_count", 32'(vcount), 32'd1);
        chk("busy_read_data", rd, 32'hA5FF_12FF);
        txn_a(1'b0, 4'h0, 32'h100, 32'h0, rd, er, lat, rl);
        chk("busy_no_write", rd, 32'hA5FF_12FF);

        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            txn_a(1'b0, 4'h0, 32'h3FFC, 32'h0, rd, er, lat, rl);
            if (i == 15) chk("b2b_last_data", rd, 32'h0BAD_F00D);
        end
        chk("b2b_span_cycles", 32'(cyc - t0), 32'(16 * (LAT + 1)));

        // Reset in the first WAIT cycle aborts the write.
        req_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = 32'h200; wd_a = 32'h1111_1111;
        @(negedge clk_i);
        req_a = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("midrst_ready", 32'(rdy_a), 32'd1);
        chk("midrst_valid", 32'(vld_a), 32'd0);
        chk("midrst_err",   32'(err_a), 32'd0);
        chk("midrst_rdata", rd_a,       32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (vld_a) vcount++;
        end
        chk("midrst_no_valid", 32'(vcount), 32'd0);
        txn_a(1'b0, 4'h0, 32'h200, 32'h0, rd, er, lat, rl);
        chk("midrst_old_data", rd, 32'h2222_2222);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(0, DEPTH - 1)) << 2;
            na = $urandom();
            txn_a(1'b1, 4'hF, pool[i], na, rd, er, lat, rl);
            ref_acc(1'b0, 1'b1, 4'hF, pool[i], na, ed, ee);
            chk("pool_a_wresp", rd, ed);
            req_z = 1'b1; we_z = 1'b1; be_z = 4'hF; addr_z = pool[i]; wd_z = na;
            @(negedge clk_i);
            req_z = 1'b0;
            ref_acc(1'b1, 1'b1, 4'hF, pool[i], na, ed, ee);
            chk("pool_z_wresp", rd_z, ed);
        end

        for (int i = 0; i < 30; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.be = 4'($urandom_range(0, 15));
            v.wd = $urandom();
            case ($urandom_range(0, 9))
                8:       v.addr = 32'h4000 + (32'($urandom_range(0, 1000)) << 2);
                9:       v.addr = $urandom() | 32'h8000_0000;
                default: v.addr = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
            endcase
            ref_acc(1'b0, v.we, v.be, v.addr, v.wd, ed, ee);
            txn_a(v.we, v.be, v.addr, v.wd, rd, er, lat, rl);
            chk($sformatf("rnd_a%0d_data", i), rd, ed);
            chk($sformatf("rnd_a%0d_err", i), 32'(er), 32'(ee));
            chk($sformatf("rnd_a%0d_latency", i), 32'(lat), 32'(LAT + 1));
        end

        for (int i = 0; i < 40; i++) begin
            act  = ($urandom_range(0, 4) != 0);
            v.we = 1'($urandom_range(0, 1));
            v.be = 4'($urandom_range(0, 15));
            v.wd = $urandom();
            case ($urandom_range(0, 9))
                8:       v.addr = 32'h4000 + (32'($urandom_range(0, 1000)) << 2);
                9:       v.addr = $urandom() | 32'h8000_0000;
                default: v.addr = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
            endcase
            req_z = act; we_z = v.we; be_z = v.be; addr_z = v.addr; wd_z = v.wd;
            @(negedge clk_i);
            chk($sformatf("rnd_z%0d_ready", i), 32'(rdy_z), 32'd1);
            chk($sformatf("rnd_z%0d_valid", i), 32'(vld_z), 32'(act));
            if (act) begin
                ref_acc(1'b1, v.we, v.be, v.addr, v.wd, ed, ee);
                chk($sformatf("rnd_z%0d_data", i), rd_z, ed);
                chk($sformatf("rnd_z%0d_err", i), 32'(err_z), 32'(ee));
            end
        end
        req_z = 1'b0;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
